// File: rtl/count_step_monitor_if.sv
// Signal bundle between a 4-bit counter/stimulus side and count_step_monitor.
// The master drives the observed count and controls; the slave returns pulses and status.
interface count_step_monitor_if #(
  parameter int WIDTH   = 4,
  parameter int TALLY_W = 8
);
  logic               enable;
  logic               clear;
  logic [WIDTH-1:0]   count_in;
  logic [WIDTH-1:0]   cmp_val;
  logic               wrap_pulse;
  logic               jump_pulse;
  logic               match_pulse;
  logic               stall_flag;
  logic [TALLY_W-1:0] wrap_count;
  logic [TALLY_W-1:0] jump_count;
  logic [WIDTH-1:0]   last_count;

  modport master (
    output enable, clear, count_in, cmp_val,
    input  wrap_pulse, jump_pulse, match_pulse, stall_flag,
    input  wrap_count, jump_count, last_count
  );

  modport slave (
    input  enable, clear, count_in, cmp_val,
    output wrap_pulse, jump_pulse, match_pulse, stall_flag,
    output wrap_count, jump_count, last_count
  );
endinterface

// File: rtl/count_step_monitor.sv
// Passive observer of a binary up counter: classifies each sampled step as
// increment, wrap, jump or hold, tallies wraps/jumps and watches for stalls.
module count_step_monitor #(
  parameter int WIDTH       = 4,
  parameter int TALLY_W     = 8,
  parameter int STALL_LIMIT = 8
) (
  input logic                clk,
  input logic                rst,
  count_step_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, PRIME, TRACK, STALLED} state_t;

  localparam logic [WIDTH-1:0]   P_ONE   = WIDTH'(1);
  localparam logic [TALLY_W-1:0] T_ONE   = TALLY_W'(1);
  localparam logic [7:0]         S_LIMIT = 8'(STALL_LIMIT);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_prev, w_prev_nxt;
  logic [7:0]         r_stall_cnt, w_stall_cnt_nxt;
  logic               r_stall_flag, w_stall_flag_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic               r_jump, w_jump_nxt;
  logic               r_match, w_match_nxt;
  logic [TALLY_W-1:0] r_wrap_cnt, w_wrap_cnt_nxt;
  logic [TALLY_W-1:0] r_jump_cnt, w_jump_cnt_nxt;

  logic w_hold, w_incr, w_wrap_step, w_jump_step;

  // Exactly one of the four step classes is true for any sample.
  assign w_hold      = (mon.count_in == r_prev);
  assign w_wrap_step = (r_prev == '1) && (mon.count_in == '0);
  assign w_incr      = (r_prev != '1) && (mon.count_in == r_prev + P_ONE);
  assign w_jump_step = !w_hold && !w_incr && !w_wrap_step;

  // NOTE: every next-value is defaulted first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_stall_cnt_nxt  = r_stall_cnt;
    w_stall_flag_nxt = r_stall_flag;
    w_wrap_nxt       = 1'b0;
    w_jump_nxt       = 1'b0;
    w_match_nxt      = 1'b0;
    w_wrap_cnt_nxt   = r_wrap_cnt;
    w_jump_cnt_nxt   = r_jump_cnt;

    case (r_state)
      IDLE: begin
        if (mon.enable) w_state_nxt = PRIME;
      end
      PRIME: begin
        // Fresh reference sample; stall history from an earlier session is dropped.
        w_prev_nxt       = mon.count_in;
        w_stall_cnt_nxt  = '0;
        w_stall_flag_nxt = 1'b0;
        w_state_nxt      = mon.enable ? TRACK : IDLE;
      end
      TRACK, STALLED: begin
        if (!mon.enable) begin
          w_state_nxt = IDLE;
        end else begin
          w_prev_nxt  = mon.count_in;
          w_match_nxt = (mon.count_in == mon.cmp_val) && !w_hold;
          if (w_hold) begin
            if (r_stall_cnt != S_LIMIT) w_stall_cnt_nxt = r_stall_cnt + 8'd1;
            if (w_stall_cnt_nxt == S_LIMIT) begin
              w_stall_flag_nxt = 1'b1;
              w_state_nxt      = STALLED;
            end
          end else begin
            w_stall_cnt_nxt  = '0;
            w_stall_flag_nxt = 1'b0;
            w_state_nxt      = TRACK;
            w_wrap_nxt       = w_wrap_step;
            w_jump_nxt       = w_jump_step;
            if (w_wrap_step && (r_wrap_cnt != '1)) w_wrap_cnt_nxt = r_wrap_cnt + T_ONE;
            if (w_jump_step && (r_jump_cnt != '1)) w_jump_cnt_nxt = r_jump_cnt + T_ONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Clear wipes tallies and stall status but leaves pulses, prev and tracking intact.
    if (mon.clear) begin
      w_wrap_cnt_nxt   = '0;
      w_jump_cnt_nxt   = '0;
      w_stall_cnt_nxt  = '0;
      w_stall_flag_nxt = 1'b0;
      if (w_state_nxt == STALLED) w_state_nxt = TRACK;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_stall_cnt  <= '0;
      r_stall_flag <= 1'b0;
      r_wrap       <= 1'b0;
      r_jump       <= 1'b0;
      r_match      <= 1'b0;
      r_wrap_cnt   <= '0;
      r_jump_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_stall_cnt  <= w_stall_cnt_nxt;
      r_stall_flag <= w_stall_flag_nxt;
      r_wrap       <= w_wrap_nxt;
      r_jump       <= w_jump_nxt;
      r_match      <= w_match_nxt;
      r_wrap_cnt   <= w_wrap_cnt_nxt;
      r_jump_cnt   <= w_jump_cnt_nxt;
    end
  end

  assign mon.wrap_pulse  = r_wrap;
  assign mon.jump_pulse  = r_jump;
  assign mon.match_pulse = r_match;
  assign mon.stall_flag  = r_stall_flag;
  assign mon.wrap_count  = r_wrap_cnt;
  assign mon.jump_count  = r_jump_cnt;
  assign mon.last_count  = r_prev;

endmodule

// File: tb/tb_count_step_monitor.sv
// Directed bench for count_step_monitor: hand-computed expectations for free-run,
// load, compare, stall watchdog, tally saturation, clear and reset re-entry.
module tb_count_step_monitor;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  count_step_monitor_if #(.WIDTH(4), .TALLY_W(8)) mon_if ();

  count_step_monitor #(.WIDTH(4), .TALLY_W(8), .STALL_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_p(input string tag, input logic w, input logic j, input logic m);
    check({tag, ".wrap"},  32'(mon_if.wrap_pulse),  32'(w));
    check({tag, ".jump"},  32'(mon_if.jump_pulse),  32'(j));
    check({tag, ".match"}, 32'(mon_if.match_pulse), 32'(m));
  endtask

  task automatic chk_tally(input string tag, input int wc, input int jc);
    check({tag, ".wrap_count"}, 32'(mon_if.wrap_count), wc);
    check({tag, ".jump_count"}, 32'(mon_if.jump_count), jc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] c);
    mon_if.count_in = c;
    tick();
  endtask

  initial begin
    logic [3:0] c;

    // Reset with a nonzero count present so last_count=0 is meaningful.
    rst = 1'b1;
    mon_if.enable   = 1'b0;
    mon_if.clear    = 1'b0;
    mon_if.count_in = 4'd9;
    mon_if.cmp_val  = 4'd8;
    tick();
    tick();
    chk_p("reset", 1'b0, 1'b0, 1'b0);
    chk_tally("reset", 0, 0);
    check("reset.stall", 32'(mon_if.stall_flag), 0);
    check("reset.last", 32'(mon_if.last_count), 0);

    // Free run 0..15,0,1: IDLE->PRIME, PRIME captures 0, then classification.
    rst = 1'b0;
    mon_if.enable = 1'b1;
    step(4'd0);
    chk_p("idle_to_prime", 1'b0, 1'b0, 1'b0);
    step(4'd0);
    chk_p("prime", 1'b0, 1'b0, 1'b0);
    check("prime.last", 32'(mon_if.last_count), 0);
    for (int i = 1; i <= 17; i++) begin
      c = 4'(i % 16);
      step(c);
      chk_p($sformatf("run%0d", i), (i == 16), 1'b0, (c == 4'd8));
    end
    chk_tally("run_end", 1, 0);
    check("run_end.last", 32'(mon_if.last_count), 1);

    // Clear on a held sample: tallies drop to zero, no pulses.
    mon_if.clear = 1'b1;
    step(4'd1);
    mon_if.clear = 1'b0;
    chk_p("clear1", 1'b0, 1'b0, 1'b0);
    chk_tally("clear1", 0, 0);

    // Load: 2..5, then 13, 14, 15, 0.
    for (int i = 2; i <= 5; i++) begin
      step(4'(i));
      chk_p($sformatf("pre_load%0d", i), 1'b0, 1'b0, 1'b0);
    end
    step(4'd13);
    chk_p("load13", 1'b0, 1'b1, 1'b0);
    step(4'd14);
    chk_p("after_load14", 1'b0, 1'b0, 1'b0);
    step(4'd15);
    chk_p("after_load15", 1'b0, 1'b0, 1'b0);
    step(4'd0);
    chk_p("load_wrap", 1'b1, 1'b0, 1'b0);
    chk_tally("load_end", 1, 1);

    // Compare 8: single match, none while held at 8.
    for (int i = 1; i <= 8; i++) begin
      step(4'(i));
      chk_p($sformatf("cmp_run%0d", i), 1'b0, 1'b0, (i == 8));
    end
    for (int k = 0; k < 3; k++) begin
      step(4'd8);
      chk_p($sformatf("cmp_hold%0d", k), 1'b0, 1'b0, 1'b0);
    end
    step(4'd9);
    chk_p("cmp_9", 1'b0, 1'b0, 1'b0);
    // Match coinciding with a jump (9 -> 3, cmp_val 3).
    mon_if.cmp_val = 4'd3;
    step(4'd3);
    chk_p("jump_match", 1'b0, 1'b1, 1'b1);
    chk_tally("jump_match", 1, 2);

    // Stall watchdog: 3->4 increment, then 8 holds raise stall_flag.
    step(4'd4);
    chk_p("stall_inc", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(4'd4);
      check($sformatf("stall_hold%0d", k), 32'(mon_if.stall_flag), 32'(k == 8));
    end
    step(4'd4);
    check("stall_sat", 32'(mon_if.stall_flag), 1);
    step(4'd5);
    check("stall_release", 32'(mon_if.stall_flag), 0);
    chk_p("stall_release", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(4'd5);
      check($sformatf("stall2_hold%0d", k), 32'(mon_if.stall_flag), 32'(k == 8));
    end
    // Clear drops stall_flag and restarts the hold count.
    mon_if.clear = 1'b1;
    step(4'd5);
    mon_if.clear = 1'b0;
    check("stall_clear", 32'(mon_if.stall_flag), 0);
    chk_tally("stall_clear", 0, 0);
    step(4'd5);
    check("stall_after_clear", 32'(mon_if.stall_flag), 0);

    // 260 pairs of 15 (jump) then 0 (wrap): both tallies saturate at 255.
    for (int i = 0; i < 260; i++) begin
      step(4'd15);
      step(4'd0);
    end
    chk_p("sat_last", 1'b1, 1'b0, 1'b0);
    chk_tally("sat", 255, 255);

    // Clear on the same edge as a jump: pulse fires, tally not counted.
    mon_if.clear = 1'b1;
    step(4'd15);
    mon_if.clear = 1'b0;
    chk_p("clear_jump", 1'b0, 1'b1, 1'b0);
    chk_tally("clear_jump", 0, 0);
    step(4'd0);
    chk_p("post_clear_wrap", 1'b1, 1'b0, 1'b0);
    step(4'd15);
    step(4'd0);
    step(4'd15);
    step(4'd0);
    chk_tally("pre_rst", 3, 2);

    // Reset mid-TRACK, then re-entry through PRIME with a would-be jump value.
    rst = 1'b1;
    step(4'd1);
    rst = 1'b0;
    chk_p("mid_rst", 1'b0, 1'b0, 1'b0);
    chk_tally("mid_rst", 0, 0);
    check("mid_rst.last", 32'(mon_if.last_count), 0);
    step(4'd7);
    chk_p("re_idle", 1'b0, 1'b0, 1'b0);
    step(4'd12);
    chk_p("re_prime", 1'b0, 1'b0, 1'b0);
    check("re_prime.last", 32'(mon_if.last_count), 12);
    step(4'd13);
    chk_p("re_inc", 1'b0, 1'b0, 1'b0);
    chk_tally("re_inc", 0, 0);

    // Disable from TRACK: no pulse, prev held; re-enable goes via PRIME.
    mon_if.enable = 1'b0;
    step(4'd2);
    chk_p("disable", 1'b0, 1'b0, 1'b0);
    check("disable.last", 32'(mon_if.last_count), 13);
    mon_if.enable = 1'b1;
    step(4'd9);
    chk_p("reen_idle", 1'b0, 1'b0, 1'b0);
    step(4'd9);
    chk_p("reen_prime", 1'b0, 1'b0, 1'b0);
    check("reen_prime.last", 32'(mon_if.last_count), 9);
    step(4'd10);
    chk_p("reen_inc", 1'b0, 1'b0, 1'b0);
    chk_tally("reen_inc", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_step_monitor.md
Name: count_step_monitor

Overview:
- Downstream observer of the 4-bit loadable binary up counter; samples its count output every clock.
- Classifies each step as increment, wrap (max->0), jump (load or counter reset) or stall (no change), and flags compare matches.
- Keeps saturating wrap and jump tallies for status readout and provides a stall watchdog.
- Purely an observer; never drives the counter.

Parameters:
WIDTH, 4, width of the observed count.
TALLY_W, 8, width of the wrap_count and jump_count tallies.
STALL_LIMIT, 8, consecutive unchanged samples in TRACK before stall_flag asserts; legal range 2..255.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
enable  input  1  monitoring enable; low forces IDLE.
clear  input  1  synchronous clear of both tallies and stall_flag; FSM state unaffected.
count_in  input  WIDTH  count value from the counter.
cmp_val  input  WIDTH  compare value; sampled every cycle.
wrap_pulse  output  1  one-cycle pulse on a max->0 step.
jump_pulse  output  1  one-cycle pulse on a non-increment, non-hold step.
match_pulse  output  1  one-cycle pulse when count_in newly equals cmp_val.
stall_flag  output  1  level; count frozen for STALL_LIMIT samples.
wrap_count  output  TALLY_W  saturating number of wraps.
jump_count  output  TALLY_W  saturating number of jumps.
last_count  output  WIDTH  previous sample (prev).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; prev=0; stall counter=0; every output=0. rst has priority over clear and enable.
- All outputs are registered. count_in sampled at edge N produces its pulse or tally update visible after edge N, so latency is 1 cycle.
- FSM states: IDLE, PRIME, TRACK, STALLED.
- IDLE: no pulses and tallies hold. enable=1 -> PRIME.
- PRIME: captures prev=count_in with no classification. Next state is TRACK if enable=1, else IDLE.
- TRACK and STALLED: enable=0 -> IDLE next edge, with no pulse for that sample. Otherwise each sample is classified against prev:
  - count_in==prev: hold. Stall counter increments, saturating at STALL_LIMIT. When it reaches STALL_LIMIT, stall_flag=1 and state=STALLED.
  - count_in==prev+1 (mod 2^WIDTH) and prev != all-ones: increment.
  - prev==all-ones and count_in==0: wrap. wrap_pulse=1; wrap_count+1, saturating at 2^TALLY_W-1.
  - Any other value: jump. jump_pulse=1; jump_count+1, saturating. A counter reset from a nonzero, non-max value, or a load, is a jump.
  - Any non-hold step clears the stall counter. In STALLED, a non-hold step also clears stall_flag and returns to TRACK on the same edge.
  - match_pulse=1 when count_in==cmp_val and count_in!=prev. There is no re-match while held. It can coincide with wrap_pulse or jump_pulse.
  - prev=count_in on every TRACK/STALLED sample.
- Exactly one of increment, wrap, jump or hold applies per sample, so wrap_pulse and jump_pulse are mutually exclusive.
- clear=1 (without rst) zeroes wrap_count, jump_count, stall_flag and the stall counter that edge. A wrap or jump classified on the same edge is not counted, but its pulse still fires. State and prev are unaffected; STALLED falls back to TRACK.
- Pulses deassert the cycle after they assert unless a new qualifying sample occurs.
- Leaving TRACK/STALLED via enable=0 and re-entering always passes through PRIME, so a stale prev never produces a spurious jump.

Test Plan:
- Reset, enable=1, counter free-runs 0..15,0,1 -> after PRIME, no jump_pulse. Exactly one wrap_pulse, on the cycle after count_in 15->0. wrap_count=1.
- Counter at 5, load 13 for one cycle, then counting resumes 14,15,0 -> one jump_pulse (5->13), then one wrap_pulse. jump_count=1, wrap_count=1.
- cmp_val=8, counter runs from 0 past 8 -> single match_pulse, one cycle after count_in=8 is sampled. Counter held at 8 for 3 cycles -> no further match_pulse.
- STALL_LIMIT=8, count held at 4 for 8 samples -> stall_flag=1 and state STALLED. Count then steps to 5 -> stall_flag=0 after that edge; no jump_pulse.
- 260 consecutive wraps -> wrap_count saturates at 255. Then clear=1 for one cycle -> wrap_count=0, jump_count=0.
- rst pulsed mid-TRACK with wrap_count=3 -> all outputs 0, state IDLE. With enable held high, re-entry passes PRIME; the first sample generates no pulse.
